// File: rtl/hex_display_scheduler.sv
// Multiplexes NUM_SRC 32-bit debug words onto one 8-digit hex display (manual/auto/freeze).
// Optional HEX_SRC_TAG_EN: leftmost digit shows the selected source index.
module hex_display_scheduler #(
    parameter int unsigned NUM_SRC         = 4,
    parameter int unsigned DWELL_CYCLES    = 50000000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    localparam int unsigned SEL_W          = $clog2(NUM_SRC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_SRC*32-1:0] src_data,
    input  logic [NUM_SRC-1:0]    src_valid,
    input  logic                  btn_next,
    input  logic                  mode_auto,
    input  logic                  freeze,
    output logic [31:0]           disp_data,
    output logic [SEL_W-1:0]      disp_sel,
    output logic                  disp_blank,
    output logic                  advance_pulse
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned DW_W = $clog2(DWELL_CYCLES);

    typedef enum logic [1:0] {ST_MANUAL, ST_AUTO, ST_FROZEN} state_t;

    logic            btn_s1_q, btn_s2_q, db_level_q, db_prev_q;
    logic [DB_W-1:0] db_cnt_q;
    logic            mode_q, freeze_q;
    state_t          state_q, state_d;
    logic [DW_W-1:0] dwell_q, dwell_d;
    logic [SEL_W-1:0] sel_q, sel_d, next_sel, low_sel;
    logic            next_found, any_valid;
    logic            blank_q, blank_d, pulse_q, pulse_d;
    logic [31:0]     data_q, data_d, cur_word;
    logic            press, tc, adv_evt, forced;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            db_level_q <= 1'b0;
            db_prev_q  <= 1'b0;
            db_cnt_q   <= '0;
        end else begin
            btn_s1_q  <= btn_next;
            btn_s2_q  <= btn_s1_q;
            db_prev_q <= db_level_q;
            if (btn_s2_q != db_level_q) begin
                if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_level_q <= btn_s2_q;
                    db_cnt_q   <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + 1'b1;
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    assign press = db_level_q & ~db_prev_q;

    always_comb begin
        next_sel   = sel_q;
        next_found = 1'b0;
        low_sel    = '0;
        any_valid  = |src_valid;
        for (int unsigned k = 1; k < NUM_SRC; k++) begin
            int unsigned idx;
            idx = (32'(sel_q) + k) % NUM_SRC;
            if (!next_found && src_valid[idx]) begin
                next_sel   = SEL_W'(idx);
                next_found = 1'b1;
            end
        end
        for (int unsigned k = NUM_SRC; k > 0; k--) begin
            if (src_valid[k-1]) low_sel = SEL_W'(k - 1);
        end
    end

    always_comb begin
        cur_word = src_data[{sel_q, 5'd0} +: 32];
`ifdef HEX_SRC_TAG_EN
        cur_word[31:28] = 4'(sel_q);
`endif
    end

    always_comb begin
        state_d = freeze_q ? ST_FROZEN : (mode_q ? ST_AUTO : ST_MANUAL);
        sel_d   = sel_q;
        blank_d = blank_q;
        data_d  = data_q;
        pulse_d = 1'b0;
        dwell_d = dwell_q;
        tc      = (dwell_q == DW_W'(DWELL_CYCLES - 1));
        adv_evt = press || (state_q == ST_AUTO && tc);
        forced  = !src_valid[sel_q];

        if (state_q != ST_FROZEN) begin
            if (!any_valid) begin
                blank_d = 1'b1;
            end else if (blank_q) begin
                sel_d   = low_sel;
                blank_d = 1'b0;
                pulse_d = 1'b1;
            end else if ((forced || adv_evt) && next_found) begin
                sel_d   = next_sel;
                pulse_d = 1'b1;
            end
            // Data follows the registered select, so a new pick shows one cycle after disp_sel moves.
            data_d = (!any_valid || blank_q) ? '0 : cur_word;
        end

        case (state_q)
            ST_AUTO:   dwell_d = (adv_evt || forced) ? '0 : dwell_q + 1'b1;
            ST_MANUAL: dwell_d = '0;
            default:   dwell_d = dwell_q;
        endcase
        if (state_q != ST_AUTO && state_d == ST_AUTO) dwell_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= 1'b0;
            freeze_q <= 1'b0;
            state_q  <= ST_MANUAL;
            dwell_q  <= '0;
            sel_q    <= '0;
            blank_q  <= 1'b1;
            pulse_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            mode_q   <= mode_auto;
            freeze_q <= freeze;
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            sel_q    <= sel_d;
            blank_q  <= blank_d;
            pulse_q  <= pulse_d;
            data_q   <= data_d;
        end
    end

    assign disp_data     = data_q;
    assign disp_sel      = sel_q;
    assign disp_blank    = blank_q;
    assign advance_pulse = pulse_q;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed bench for hex_display_scheduler (NUM_SRC=4, DWELL=8, DEBOUNCE=4).
module tb_hex_display_scheduler;

    localparam int unsigned N = 4;
`ifdef HEX_SRC_TAG_EN
    localparam bit TAG = 1'b1;
`else
    localparam bit TAG = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*32-1:0] src_data;
    logic [N-1:0]    src_valid;
    logic            btn_next, mode_auto, freeze;
    logic [31:0]     disp_data;
    logic [1:0]      disp_sel;
    logic            disp_blank, advance_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;

    hex_display_scheduler #(
        .NUM_SRC(4),
        .DWELL_CYCLES(8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_valid(src_valid),
        .btn_next(btn_next), .mode_auto(mode_auto), .freeze(freeze),
        .disp_data(disp_data), .disp_sel(disp_sel), .disp_blank(disp_blank),
        .advance_pulse(advance_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n === 1'b1 && advance_pulse === 1'b1) pulse_cnt++;

    function automatic logic [31:0] exp_word(input int s, input logic [31:0] w);
        return TAG ? {4'(s), w[27:0]} : w;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_words();
        src_data[31:0]   = 32'h11111111;
        src_data[63:32]  = 32'h22222222;
        src_data[95:64]  = 32'h33333333;
        src_data[127:96] = 32'h44444444;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(3);
    endtask

    task automatic press_btn();
        btn_next = 1'b1;
        step(8);
        btn_next = 1'b0;
        step(8);
    endtask

    task automatic test_reset();
        bit ok;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(4);
        n_checks++;
        if (disp_data !== exp_word(0, 32'h11111111) || disp_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_init: data=%h sel=%0d required %h sel 0", disp_data, disp_sel, exp_word(0, 32'h11111111));
        end
        press_btn();
        n_checks++;
        if (disp_sel !== 2'd1) begin
            n_fail++;
            $display("FAIL reset_pre_press: sel=%0d required 1", disp_sel);
        end
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (disp_data !== 32'h0 || disp_sel !== 2'd0 || disp_blank !== 1'b1 || advance_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: data=%h sel=%0d blank=%b pulse=%b required 0/0/1/0",
                     disp_data, disp_sel, disp_blank, advance_pulse);
        end
        #1 rst_n = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 3 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (disp_sel === 2'd0 && disp_blank === 1'b0 && disp_data === exp_word(0, 32'h11111111)) ok = 1'b1;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL reset_release: data=%h sel=%0d blank=%b required %h sel 0 within 3 cycles",
                     disp_data, disp_sel, disp_blank, exp_word(0, 32'h11111111));
        end
    endtask

    task automatic test_manual_debounce();
        int base;
        base = pulse_cnt;
        for (int i = 0; i < 10; i++) begin
            btn_next = ((i / 2) % 2 == 0);
            step(1);
        end
        btn_next = 1'b1;
        step(10);
        btn_next = 1'b0;
        step(10);
        n_checks++;
        if (pulse_cnt - base !== 1) begin
            n_fail++;
            $display("FAIL manual_pulses: got %0d required 1", pulse_cnt - base);
        end
        n_checks++;
        if (disp_sel !== 2'd1 || disp_data !== exp_word(1, 32'h22222222)) begin
            n_fail++;
            $display("FAIL manual_sel: sel=%0d data=%h required 1 %h", disp_sel, disp_data, exp_word(1, 32'h22222222));
        end
    endtask

    task automatic test_auto_rotation();
        int n;
        apply_reset();
        src_valid = 4'b1011;
        mode_auto = 1'b1;
        n = 0;
        do begin step(1); n++; end while (advance_pulse !== 1'b1 && n < 20);
        n_checks++;
        if (advance_pulse !== 1'b1 || disp_sel !== 2'd1) begin
            n_fail++;
            $display("FAIL auto_first: sel=%0d pulse=%b required 1 1", disp_sel, advance_pulse);
        end
        step(1);
        n_checks++;
        if (disp_data !== exp_word(1, 32'h22222222)) begin
            n_fail++;
            $display("FAIL auto_data1: got %h required %h", disp_data, exp_word(1, 32'h22222222));
        end
        n = 1;
        do begin step(1); n++; end while (advance_pulse !== 1'b1 && n < 20);
        n_checks++;
        if (n !== 8 || disp_sel !== 2'd3) begin
            n_fail++;
            $display("FAIL auto_skip: sel=%0d after %0d cycles required 3 after 8", disp_sel, n);
        end
        n = 0;
        do begin step(1); n++; end while (advance_pulse !== 1'b1 && n < 20);
        n_checks++;
        if (n !== 8 || disp_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL auto_wrap: sel=%0d after %0d cycles required 0 after 8", disp_sel, n);
        end
    endtask

    // Entered right after an auto advance was observed; the press is timed to land on the next terminal count.
    task automatic test_simultaneous();
        int extra;
        step(1);
        btn_next = 1'b1;
        step(7);
        n_checks++;
        if (advance_pulse !== 1'b1 || disp_sel !== 2'd1) begin
            n_fail++;
            $display("FAIL simul_adv: sel=%0d pulse=%b required 1 1", disp_sel, advance_pulse);
        end
        btn_next = 1'b0;
        extra = 0;
        for (int i = 0; i < 7; i++) begin
            step(1);
            if (advance_pulse === 1'b1) extra++;
        end
        n_checks++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL simul_single: extra advances %0d required 0", extra);
        end
        step(1);
        n_checks++;
        if (advance_pulse !== 1'b1 || disp_sel !== 2'd3) begin
            n_fail++;
            $display("FAIL simul_restart: sel=%0d pulse=%b required 3 1 eight cycles later", disp_sel, advance_pulse);
        end
        mode_auto = 1'b0;
    endtask

    task automatic test_freeze();
        int base;
        src_valid = 4'b1111;
        apply_reset();
        press_btn();
        press_btn();
        n_checks++;
        if (disp_sel !== 2'd2) begin
            n_fail++;
            $display("FAIL freeze_setup: sel=%0d required 2", disp_sel);
        end
        freeze = 1'b1;
        step(3);
        base = pulse_cnt;
        src_data[95:64] = 32'hAAAAAAAA;
        press_btn();
        src_valid[2] = 1'b0;
        step(3);
        n_checks++;
        if (disp_sel !== 2'd2 || disp_data !== exp_word(2, 32'h33333333) || disp_blank !== 1'b0 || pulse_cnt !== base) begin
            n_fail++;
            $display("FAIL freeze_hold: sel=%0d data=%h blank=%b pulses=%0d required 2 %h 0 0",
                     disp_sel, disp_data, disp_blank, pulse_cnt - base, exp_word(2, 32'h33333333));
        end
        freeze = 1'b0;
        step(5);
        n_checks++;
        if (disp_sel !== 2'd3 || pulse_cnt - base !== 1) begin
            n_fail++;
            $display("FAIL freeze_release: sel=%0d pulses=%0d required 3 1", disp_sel, pulse_cnt - base);
        end
        step(1);
        n_checks++;
        if (disp_data !== exp_word(3, 32'h44444444)) begin
            n_fail++;
            $display("FAIL freeze_data: got %h required %h", disp_data, exp_word(3, 32'h44444444));
        end
    endtask

    task automatic test_all_invalid();
        int base;
        src_data[95:64] = 32'h33333333;
        src_valid = 4'b0000;
        step(2);
        n_checks++;
        if (disp_blank !== 1'b1 || disp_data !== 32'h0 || disp_sel !== 2'd3) begin
            n_fail++;
            $display("FAIL blank: blank=%b data=%h sel=%0d required 1 0 3", disp_blank, disp_data, disp_sel);
        end
        base = pulse_cnt;
        src_valid = 4'b0100;
        step(1);
        n_checks++;
        if (disp_sel !== 2'd2 || disp_blank !== 1'b0 || advance_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL recover: sel=%0d blank=%b pulse=%b required 2 0 1", disp_sel, disp_blank, advance_pulse);
        end
        step(1);
        n_checks++;
        if (disp_data !== exp_word(2, 32'h33333333)) begin
            n_fail++;
            $display("FAIL recover_data: got %h required %h", disp_data, exp_word(2, 32'h33333333));
        end
        press_btn();
        n_checks++;
        if (disp_sel !== 2'd2 || pulse_cnt - base !== 1) begin
            n_fail++;
            $display("FAIL sole_valid: sel=%0d pulses=%0d required 2 1", disp_sel, pulse_cnt - base);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        btn_next  = 1'b0;
        mode_auto = 1'b0;
        freeze    = 1'b0;
        src_valid = 4'b1111;
        set_words();
        test_reset();
        test_manual_debounce();
        test_auto_rotation();
        test_simultaneous();
        test_freeze();
        test_all_invalid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
